// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU encodings for the EX/MEM stage and ALU
// Contents: opcode_t (MIPS primary opcodes), aluop_t (ALU functions),
// fwd_t (operand forwarding selects), REG_RA (link register index),
// stage_state_t (EX/MEM stage state machine).
package cpu_types_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0a,
    OP_SLTIU = 6'h0b,
    OP_ANDI  = 6'h0c,
    OP_ORI   = 6'h0d,
    OP_XORI  = 6'h0e,
    OP_LUI   = 6'h0f,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b,
    OP_HALT  = 6'h3f
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  // Select value 3 is unused and falls back to the ID/EX operand.
  typedef enum logic [1:0] {
    FWD_IDEX  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_WB    = 2'd2
  } fwd_t;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    ST_RUN, ST_MEMWAIT, ST_HALTED
  } stage_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit MIPS-style ALU
// Ports: porta/portb operands, shamt shift amount, aluop function select;
// result, zero (result==0), overflow (signed ADD/SUB overflow only).
module alu
  import cpu_types_pkg::*;
(
  input  logic [31:0] porta,
  input  logic [31:0] portb,
  input  logic [4:0]  shamt,
  input  aluop_t      aluop,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (aluop)
      ALU_SLL:  result = portb << shamt;
      ALU_SRL:  result = portb >> shamt;
      ALU_ADD: begin
        result   = porta + portb;
        // like-signed operands producing a differently-signed sum
        overflow = (porta[31] == portb[31]) & (result[31] != porta[31]);
      end
      ALU_SUB: begin
        result   = porta - portb;
        // unlike-signed operands where the result takes B's sign
        overflow = (porta[31] != portb[31]) & (result[31] != porta[31]);
      end
      ALU_AND:  result = porta & portb;
      ALU_OR:   result = porta | portb;
      ALU_XOR:  result = porta ^ portb;
      ALU_NOR:  result = ~(porta | portb);
      ALU_SLT:  result = {31'b0, $signed(porta) < $signed(portb)};
      ALU_SLTU: result = {31'b0, porta < portb};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline stage: forwarding, ALU, branch resolve, mem handshake
// Ports: CLK; nRST (async, active-high); ID/EX operands and controls (*_in);
// fwdA_sel/fwdB_sel + wb_dat forwarding; ihit/dhit/stall/flush handshake;
// registered EX/MEM latch (alu_out, store_dat, npc_out, wsel_out, RegWr_out,
// MemtoReg_out, dREN_out, dWEN_out, halt_out, ovf_out); combinational
// flush_branch, branch_target, mem_busy.
// Build option: OVF_TRAP_EN - overflowing ADD/SUB suppresses the register
// write and sets a sticky ovf_out; otherwise ovf_out is tied 0.
module ex_mem_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  opcode_t     opcode_in,
  input  aluop_t      ALUOP_in,
  input  logic [31:0] rdat1_in,
  input  logic [31:0] rdat2_in,
  input  logic [31:0] imm32_in,
  input  logic [31:0] npc_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic        RegDst_in,
  input  logic        ALUSrc_in,
  input  logic        RegWr_in,
  input  logic        MemtoReg_in,
  input  logic        MemWr_in,
  input  logic        JAL_in,
  input  logic        BEQ_in,
  input  logic        BNE_in,
  input  logic        halt_in,
  input  logic [1:0]  fwdA_sel,
  input  logic [1:0]  fwdB_sel,
  input  logic [31:0] wb_dat,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] alu_out,
  output logic [31:0] store_dat,
  output logic [31:0] npc_out,
  output logic [4:0]  wsel_out,
  output logic        RegWr_out,
  output logic        MemtoReg_out,
  output logic        dREN_out,
  output logic        dWEN_out,
  output logic        halt_out,
  output logic        ovf_out,
  output logic        flush_branch,
  output logic [31:0] branch_target,
  output logic        mem_busy
);

  stage_state_t state;
  logic [31:0]  opa, fwd_b, opb, alu_res, wdat;
  logic [4:0]   wsel;
  logic         alu_zero, alu_ovf, advance, trap, mem_req, load;

  always_comb begin
    opa = rdat1_in;
    if (fwdA_sel == FWD_EXMEM)   opa = alu_out;
    else if (fwdA_sel == FWD_WB) opa = wb_dat;
    fwd_b = rdat2_in;
    if (fwdB_sel == FWD_EXMEM)   fwd_b = alu_out;
    else if (fwdB_sel == FWD_WB) fwd_b = wb_dat;
  end

  assign opb = ALUSrc_in ? imm32_in : fwd_b;

  alu u_alu (
    .porta   (opa),
    .portb   (opb),
    .shamt   (imm32_in[10:6]),
    .aluop   (ALUOP_in),
    .result  (alu_res),
    .zero    (alu_zero),
    .overflow(alu_ovf)
  );

  assign wsel          = JAL_in ? REG_RA : (RegDst_in ? rd_in : rt_in);
  assign wdat          = JAL_in ? npc_in : alu_res;
  assign flush_branch  = (BEQ_in & (opa == opb)) | (BNE_in & (opa != opb));
  assign branch_target = npc_in + {imm32_in[29:0], 2'b00};
  assign mem_busy      = (state == ST_MEMWAIT);
  assign advance       = (state == ST_RUN) & ihit & ~stall;
  assign mem_req       = MemtoReg_in | MemWr_in;
  assign load          = advance & ~flush;

`ifdef OVF_TRAP_EN
  assign trap = alu_ovf;

  // Sticky: only reset clears it, bubbles leave it alone.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST)              ovf_out <= 1'b0;
    else if (load && trap) ovf_out <= 1'b1;
  end
`else
  assign trap    = 1'b0;
  assign ovf_out = 1'b0;
`endif

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state        <= ST_RUN;
      alu_out      <= '0;
      store_dat    <= '0;
      npc_out      <= '0;
      wsel_out     <= '0;
      RegWr_out    <= 1'b0;
      MemtoReg_out <= 1'b0;
      dREN_out     <= 1'b0;
      dWEN_out     <= 1'b0;
      halt_out     <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (advance) begin
            if (flush) begin
              alu_out      <= '0;
              store_dat    <= '0;
              npc_out      <= '0;
              wsel_out     <= '0;
              RegWr_out    <= 1'b0;
              MemtoReg_out <= 1'b0;
              dREN_out     <= 1'b0;
              dWEN_out     <= 1'b0;
              halt_out     <= 1'b0;
            end else begin
              alu_out      <= wdat;
              store_dat    <= fwd_b;
              npc_out      <= npc_in;
              wsel_out     <= wsel;
              RegWr_out    <= RegWr_in & ~trap;
              MemtoReg_out <= MemtoReg_in;
              dREN_out     <= MemtoReg_in;
              dWEN_out     <= MemWr_in;
              halt_out     <= halt_in;
              // halt wins over a memory request: the stage freezes for good
              if (halt_in)      state <= ST_HALTED;
              else if (mem_req) state <= ST_MEMWAIT;
            end
          end
        end
        ST_MEMWAIT: begin
          // dhit only releases; an ihit in the same cycle does not load
          if (dhit) begin
            dREN_out <= 1'b0;
            dWEN_out <= 1'b0;
            state    <= ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{opcode_in, pc_in, alu_zero, alu_ovf};

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have ports: CLK in 1 clock (rising edge); nRST in 1 reset, asynchronous, active-high (1 = reset).
REQ-002 SHALL have ID/EX-side inputs:
- opcode_in (opcode_t), ALUOP_in (aluop_t)
- rdat1_in, rdat2_in, imm32_in, npc_in, pc_in, each 32
- rt_in, rd_in, each 5
- RegDst_in, ALUSrc_in, RegWr_in, MemtoReg_in, MemWr_in, JAL_in, BEQ_in, BNE_in, halt_in, each 1
REQ-003 SHALL have forwarding inputs: fwdA_sel, fwdB_sel, each 2 (0 = ID/EX operand, 1 = this stage's alu_out, 2 = wb_dat); wb_dat 32.
REQ-004 SHALL have control inputs: ihit 1, dhit 1, stall 1, flush 1.
REQ-005 SHALL have registered outputs:
- alu_out 32, store_dat 32, npc_out 32, wsel_out 5
- RegWr_out, MemtoReg_out, dREN_out, dWEN_out, halt_out, ovf_out, each 1
REQ-006 SHALL have combinational outputs: flush_branch 1, branch_target 32, mem_busy 1.

Function
REQ-007 Operand A SHALL be the fwdA_sel-selected value; operand B SHALL be imm32_in when ALUSrc_in=1, otherwise the fwdB_sel-selected value; store data SHALL always be the fwdB_sel-selected value.
REQ-008 ALU operations SHALL be:
- SLL/SRL: B shifted by imm32_in[10:6]
- ADD/SUB: 32-bit wrap
- AND, OR, XOR, NOR
- SLT: signed compare; SLTU: unsigned compare
REQ-009 Overflow SHALL be detected on ADD/SUB only, using the operand sign bits vs the result sign bit.
REQ-010 Destination register: JAL_in=1 gives wsel 31 with result npc_in; otherwise RegDst_in ? rd_in : rt_in.
REQ-011 flush_branch SHALL equal (BEQ_in & A==B) | (BNE_in & A!=B), evaluated on forwarded operands, in the same cycle.
REQ-012 branch_target SHALL equal npc_in + (imm32_in << 2), modulo 2^32.
REQ-013 State machine RUN/MEMWAIT/HALTED; mem_busy SHALL be 1 exactly in MEMWAIT.
REQ-014 advance SHALL be defined as (state==RUN) & ihit & ~stall.
REQ-015 In RUN with advance=1, the latch SHALL load:
- all outputs from computed values
- dREN_out=MemtoReg_in, dWEN_out=MemWr_in
REQ-016 A load per REQ-015 with MemtoReg_in|MemWr_in set SHALL move the state to MEMWAIT.
REQ-017 In MEMWAIT, outputs SHALL hold until dhit=1; on the dhit edge, dREN_out/dWEN_out SHALL go 0 and the state SHALL return to RUN. Requests are therefore one-shot.
REQ-018 flush=1 with advance=1 SHALL load a bubble: all outputs 0, state RUN. flush SHALL be ignored in MEMWAIT.
REQ-019 Loading halt_in=1 SHALL set halt_out=1 and enter HALTED. HALTED SHALL hold all outputs until reset and SHALL ignore ihit/flush.
REQ-020 When advance=0 in RUN, all registered outputs SHALL hold.
REQ-021 Simultaneous dhit and ihit in MEMWAIT SHALL release only (RUN next cycle, no load that cycle).

Reset
REQ-022 Reset SHALL set every registered output and ovf_out to 0 and the state to RUN, asynchronously, including mid-MEMWAIT (request dropped).

Configuration
REQ-023 With OVF_TRAP_EN defined, an overflowing ADD/SUB that loads SHALL:
- force RegWr_out=0
- set ovf_out=1, sticky until reset
REQ-024 Without OVF_TRAP_EN, overflow SHALL be ignored and ovf_out SHALL be tied 0.

Structure
REQ-025 aluop_t, opcode_t, fwd-select encodings and the register index 31 SHALL live in cpu_types_pkg.
REQ-026 The ALU SHALL be a sub-module named alu (operands, aluop in; result, zero, overflow out). The stage state machine and forwarding muxes SHALL live in ex_mem_stage.

Verification
REQ-027 Bench SHALL cover:
- ADD rdat1=5, rdat2=7, RegDst=1, rd=3, ihit=1 -> next cycle alu_out=12, wsel_out=3, RegWr_out=1.
- LW with dhit low 3 cycles -> dREN_out=1, mem_busy=1 for 3 cycles; after dhit, dREN_out=0, state RUN.
- BEQ rdat1=rdat2=9, npc=0x104, imm32=4 -> flush_branch=1 same cycle, branch_target=0x114.
- fwdA_sel=2, wb_dat=0x10, SUB rdat2=1 -> alu_out=0xF.
- ADD 0x7FFFFFFF+1 with OVF_TRAP_EN -> RegWr_out=0, ovf_out=1; without the macro -> alu_out=0x80000000, RegWr_out=1.
- halt_in=1, then flush, ihit toggling and reset mid-MEMWAIT -> outputs held while HALTED; reset clears all outputs and returns the state to RUN.
